// File: rtl/scariv_alu_issue_alloc_pick.sv
// ALU issue-queue allocator and oldest-ready picker: hands out free entries lowest-first,
// tracks relative age in a matrix, and retires entries through a one-cycle clear pulse.
module scariv_alu_issue_alloc_pick #(
  parameter int ENTRY_SIZE = 8,
  parameter int IDX_W      = $clog2(ENTRY_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_disp_valid,
  output logic                  o_disp_ready,
  output logic [ENTRY_SIZE-1:0] o_put_oh,
  input  logic [ENTRY_SIZE-1:0] i_entry_ready,
  output logic [ENTRY_SIZE-1:0] o_entry_picked,
  output logic                  o_pick_valid,
  output logic [IDX_W-1:0]      o_pick_index,
  input  logic [ENTRY_SIZE-1:0] i_issue_succeeded,
  output logic [ENTRY_SIZE-1:0] o_clear_entry,
  output logic [IDX_W:0]        o_free_count
);

  logic [ENTRY_SIZE-1:0] r_busy;
  logic [ENTRY_SIZE-1:0] r_clear;
  logic [ENTRY_SIZE-1:0] r_age [ENTRY_SIZE];

  logic [ENTRY_SIZE-1:0] free_oh;
  logic                  free_found;
  logic [ENTRY_SIZE-1:0] pick_req;
  logic [ENTRY_SIZE-1:0] older_req;

  assign o_disp_ready  = |(~r_busy);
  assign o_put_oh      = (i_disp_valid && o_disp_ready) ? free_oh : '0;
  assign o_clear_entry = r_clear;
  assign pick_req      = i_entry_ready & r_busy;

  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      if (!r_busy[i] && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  // An entry wins when no other requesting entry is recorded as older than it.
  always_comb begin
    older_req      = '0;
    o_entry_picked = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      for (int j = 0; j < ENTRY_SIZE; j++) begin
        if (pick_req[j] && r_age[j][i]) older_req[i] = 1'b1;
      end
      o_entry_picked[i] = pick_req[i] & ~older_req[i];
    end
  end

  always_comb begin
    o_pick_index = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      if (o_entry_picked[i]) o_pick_index = o_pick_index | IDX_W'(i);
    end
  end

  assign o_pick_valid = |o_entry_picked;

  always_comb begin
    o_free_count = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      o_free_count = o_free_count + {{IDX_W{1'b0}}, ~r_busy[i]};
    end
  end

  // A new entry is younger than every surviving busy entry; a cleared entry drops all relations.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_busy  <= '0;
      r_clear <= '0;
      for (int i = 0; i < ENTRY_SIZE; i++) r_age[i] <= '0;
    end else begin
      r_clear <= i_issue_succeeded & ~r_clear;
      r_busy  <= (r_busy & ~r_clear) | o_put_oh;
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        for (int j = 0; j < ENTRY_SIZE; j++) begin
          if (o_put_oh[i]) begin
            r_age[i][j] <= 1'b0;
          end else if (o_put_oh[j]) begin
            r_age[i][j] <= r_busy[i] & ~r_clear[i];
          end else if (r_clear[i] || r_clear[j]) begin
            r_age[i][j] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef SIMULATION
  always @(posedge i_clk) begin
    if (i_reset_n) begin
      if (|(i_issue_succeeded & ~r_busy))
        $fatal(1, "issue_succeeded on a non-busy entry: %b busy=%b", i_issue_succeeded, r_busy);
      if (!$onehot0(o_entry_picked))
        $fatal(1, "entry_picked not one-hot: %b", o_entry_picked);
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        for (int j = 0; j < ENTRY_SIZE; j++) begin
          if (r_busy[i] && r_busy[j] && r_age[i][j] && r_age[j][i])
            $fatal(1, "age matrix cycle between %0d and %0d", i, j);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_scariv_alu_issue_alloc_pick.sv
// Self-checking bench: directed scenarios plus random traffic against an age-ordered queue model.
module tb_scariv_alu_issue_alloc_pick;

  localparam int E  = 8;
  localparam int IW = $clog2(E);

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_disp_valid = 1'b0;
  logic [E-1:0]  i_entry_ready = '0;
  logic [E-1:0]  i_issue_succeeded = '0;
  logic          o_disp_ready;
  logic [E-1:0]  o_put_oh;
  logic [E-1:0]  o_entry_picked;
  logic          o_pick_valid;
  logic [IW-1:0] o_pick_index;
  logic [E-1:0]  o_clear_entry;
  logic [IW:0]   o_free_count;

  scariv_alu_issue_alloc_pick #(.ENTRY_SIZE(E)) dut (
    .i_clk             (i_clk),
    .i_reset_n         (i_reset_n),
    .i_disp_valid      (i_disp_valid),
    .o_disp_ready      (o_disp_ready),
    .o_put_oh          (o_put_oh),
    .i_entry_ready     (i_entry_ready),
    .o_entry_picked    (o_entry_picked),
    .o_pick_valid      (o_pick_valid),
    .o_pick_index      (o_pick_index),
    .i_issue_succeeded (i_issue_succeeded),
    .o_clear_entry     (o_clear_entry),
    .o_free_count      (o_free_count)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  // Reference model: busy set, pending clear pulses, and busy entries listed oldest first.
  logic [E-1:0] m_busy = '0;
  logic [E-1:0] m_clear = '0;
  int           age_q[$];
  logic [E-1:0] exp_put = '0;

  logic [E-1:0] last_put, last_pick, last_clear;
  logic [31:0]  last_idx, last_free;
  logic         last_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [E-1:0] e_pick;
    int           e_idx;
    int           e_free;
    exp_put = '0;
    if (i_disp_valid) begin
      for (int i = 0; i < E; i++) begin
        if (!m_busy[i]) begin
          exp_put[i] = 1'b1;
          break;
        end
      end
    end
    e_pick = '0;
    e_idx  = 0;
    foreach (age_q[k]) begin
      if (i_entry_ready[age_q[k]]) begin
        e_pick[age_q[k]] = 1'b1;
        e_idx = age_q[k];
        break;
      end
    end
    e_free = 0;
    for (int i = 0; i < E; i++) if (!m_busy[i]) e_free++;
    check("disp_ready", 32'(o_disp_ready), 32'(e_free != 0));
    check("put_oh", 32'(o_put_oh), 32'(exp_put));
    check("entry_picked", 32'(o_entry_picked), 32'(e_pick));
    check("pick_valid", 32'(o_pick_valid), 32'(e_pick != '0));
    check("pick_index", 32'(o_pick_index), 32'(e_idx));
    check("clear_entry", 32'(o_clear_entry), 32'(m_clear));
    check("free_count", 32'(o_free_count), 32'(e_free));
    last_put   = o_put_oh;
    last_pick  = o_entry_picked;
    last_clear = o_clear_entry;
    last_idx   = 32'(o_pick_index);
    last_free  = 32'(o_free_count);
    last_ready = o_disp_ready;
  endtask

  task automatic modelUpdate();
    logic [E-1:0] nxt_clear;
    nxt_clear = i_issue_succeeded & ~m_clear;
    for (int k = 0; k < E; k++) begin
      if (m_clear[k]) begin
        m_busy[k] = 1'b0;
        for (int q = 0; q < age_q.size(); q++) begin
          if (age_q[q] == k) begin
            age_q.delete(q);
            break;
          end
        end
      end
    end
    for (int k = 0; k < E; k++) begin
      if (exp_put[k]) begin
        m_busy[k] = 1'b1;
        age_q.push_back(k);
      end
    end
    m_clear = nxt_clear;
  endtask

  task automatic applyStimulus(input logic dv, input logic [E-1:0] rdy, input logic [E-1:0] succ);
    @(negedge i_clk);
    i_disp_valid      = dv;
    i_entry_ready     = rdy;
    i_issue_succeeded = succ;
    #1;
    checkOutput();
    @(posedge i_clk);
    modelUpdate();
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_disp_valid      = 1'b0;
    i_entry_ready     = '0;
    i_issue_succeeded = '0;
    i_reset_n         = 1'b0;
    m_busy  = '0;
    m_clear = '0;
    age_q.delete();
    #1;
    checkOutput();
    check("reset_free_count", last_free, E);
    check("reset_clear", 32'(last_clear), 0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  initial begin
    logic [E-1:0] rdy, succ, one;
    doReset();

    // Fill from empty: lowest-index allocation each cycle.
    for (int i = 0; i < E; i++) begin
      applyStimulus(1'b1, '0, '0);
      one = '0;
      one[i] = 1'b1;
      check("fill_put", 32'(last_put), 32'(one));
    end
    applyStimulus(1'b1, '0, '0);
    check("full_disp_ready", 32'(last_ready), 0);
    check("full_free_count", last_free, 0);

    // Full queue: the cycle carrying the clear pulse must not allocate.
    applyStimulus(1'b0, '0, 8'h10);
    applyStimulus(1'b1, '0, '0);
    check("clr4_no_put", 32'(last_put), 0);
    check("clr4_pulse", 32'(last_clear), 32'h10);
    applyStimulus(1'b1, '0, '0);
    check("clr4_realloc", 32'(last_put), 32'h10);

    // Allocate 0 while clearing 6; the fresh 6 is younger than 0.
    applyStimulus(1'b0, '0, 8'h01);
    applyStimulus(1'b0, '0, 8'h40);
    applyStimulus(1'b1, '0, '0);
    check("same_cyc_put0", 32'(last_put), 32'h01);
    check("same_cyc_clr6", 32'(last_clear), 32'h40);
    applyStimulus(1'b1, '0, '0);
    check("realloc6", 32'(last_put), 32'h40);
    applyStimulus(1'b0, 8'h41, '0);
    check("pick_0_over_6", last_idx, 0);
    check("picked_oh_0", 32'(last_pick), 32'h01);

    // Success held two cycles: a single pulse, realloc in the third cycle.
    applyStimulus(1'b0, '0, 8'h04);
    check("hold_clr_c1", 32'(last_clear), 0);
    applyStimulus(1'b0, '0, 8'h04);
    check("hold_clr_c2", 32'(last_clear), 32'h04);
    applyStimulus(1'b1, '0, '0);
    check("hold_realloc", 32'(last_put), 32'h04);
    check("hold_clr_c3", 32'(last_clear), 0);

    // Allocation order 3, 1, 5 decides pick priority.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, '0, '0);
    applyStimulus(1'b0, '0, 8'h08);
    applyStimulus(1'b0, '0, '0);
    applyStimulus(1'b1, '0, '0);
    check("alloc3", 32'(last_put), 32'h08);
    applyStimulus(1'b0, '0, 8'h02);
    applyStimulus(1'b0, '0, '0);
    applyStimulus(1'b1, '0, '0);
    check("alloc1", 32'(last_put), 32'h02);
    applyStimulus(1'b0, '0, 8'h20);
    applyStimulus(1'b0, '0, '0);
    applyStimulus(1'b1, '0, '0);
    check("alloc5", 32'(last_put), 32'h20);
    applyStimulus(1'b0, 8'h2a, '0);
    check("pick3", last_idx, 3);
    applyStimulus(1'b0, 8'h22, '0);
    check("pick1", last_idx, 1);

    // Reset with a clear pending and five entries busy.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, '0, '0);
    applyStimulus(1'b0, '0, 8'h04);
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, '0);
      check("post_reset_no_clear", 32'(last_clear), 0);
    end

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rdy  = E'($urandom);
      succ = '0;
      if ($urandom_range(0, 2) == 0) succ[$urandom_range(0, E-1)] = 1'b1;
      succ = succ & m_busy;
      applyStimulus(1'($urandom_range(0, 1)), rdy, succ);
      if ($urandom_range(0, 199) == 0) doReset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
